// File: rtl/bi_set_reply_arb.sv
// Buffered round-robin/fixed-priority merger of LENGTH BiSet reply channels onto one registered reply port.
// Optional macro BISET_REPLYARB_RR_EN selects round-robin arbitration; undefined gives fixed lowest-index priority.

package BiSet;
  typedef struct packed {
    logic        valid;
    logic [3:0]  id;
    logic [15:0] data;
  } biSetReply;

  function automatic logic BiSetReplyValid(input biSetReply r);
    return r.valid;
  endfunction
endpackage

module bi_set_reply_arb #(
  parameter int LENGTH = 2,
  parameter int DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  BiSet::biSetReply  in_i [LENGTH],
  input  logic              clear_i,
  output BiSet::biSetReply  out_o,
  output logic [LENGTH-1:0] overflow_o,
  output logic              busy_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  BiSet::biSetReply  mem [LENGTH][DEPTH];
  logic [PW-1:0]     rd_ptr [LENGTH];
  logic [PW-1:0]     wr_ptr [LENGTH];
  logic [CW-1:0]     count  [LENGTH];
  logic [LENGTH-1:0] nonempty, full, push, pop, accept, drop;
  logic              gnt_valid;
  logic [IW-1:0]     gnt_idx;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    nonempty = '0;
    full     = '0;
    push     = '0;
    for (int n = 0; n < LENGTH; n++) begin
      nonempty[n] = (count[n] != '0);
      full[n]     = (count[n] == CW'(DEPTH));
      push[n]     = BiSet::BiSetReplyValid(in_i[n]);
    end
  end

`ifdef BISET_REPLYARB_RR_EN
  logic [IW-1:0] last;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= LENGTH; k++) begin
      if (!gnt_valid && nonempty[(int'(last) + k) % LENGTH]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'((int'(last) + k) % LENGTH);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)        last <= IW'(LENGTH - 1);
    else if (gnt_valid) last <= gnt_idx;
  end
`else
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = LENGTH - 1; k >= 0; k--) begin
      if (nonempty[k]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(k);
      end
    end
  end
`endif

  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  always_comb begin
    pop    = '0;
    accept = '0;
    drop   = '0;
    for (int n = 0; n < LENGTH; n++) begin
      pop[n]    = gnt_valid && (gnt_idx == IW'(n));
      accept[n] = push[n] && (!full[n] || pop[n]);
      drop[n]   = push[n] && full[n] && !pop[n];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int n = 0; n < LENGTH; n++) begin
      if (accept[n]) mem[n][wr_ptr[n]] <= in_i[n];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int n = 0; n < LENGTH; n++) begin
        rd_ptr[n] <= '0;
        wr_ptr[n] <= '0;
        count[n]  <= '0;
      end
      out_o      <= '0;
      overflow_o <= '0;
    end else begin
      for (int n = 0; n < LENGTH; n++) begin
        if (accept[n]) wr_ptr[n] <= next_ptr(wr_ptr[n]);
        if (pop[n])    rd_ptr[n] <= next_ptr(rd_ptr[n]);
        if (accept[n] && !pop[n])      count[n] <= count[n] + 1'b1;
        else if (!accept[n] && pop[n]) count[n] <= count[n] - 1'b1;
      end
      // A drop in the clearing cycle wins so no loss goes unreported.
      overflow_o <= (overflow_o & ~{LENGTH{clear_i}}) | drop;
      out_o      <= gnt_valid ? mem[gnt_idx][rd_ptr[gnt_idx]] : '0;
    end
  end

  assign busy_o = |nonempty;

endmodule
